ex_muldiv_unit: RTL

//  Multi-cycle multiply/divide unit for the EX stage, with its own HI/LO register pair.

---
 rtl/ex_muldiv_unit_pkg.sv | 33 +++
 rtl/muldiv_divider.sv | 50 +++++
 rtl/ex_muldiv_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Op codes, FSM state encoding and op-class helpers shared by the EX-stage mul/div unit.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_SIGN = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient bit per step.
module muldiv_divider
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [WIDTH:0]   shifted_s, trial_s;

  // Shift in the next dividend bit and try subtracting the divisor
  always_comb begin
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvs_q};
  end

  // Partial remainder / quotient shift register; a negative trial restores the shifted value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q <= {WIDTH{1'b0}};
      rem_q <= {WIDTH{1'b0}};
      dvs_q <= {WIDTH{1'b0}};
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= {WIDTH{1'b0}};
      dvs_q <= divisor_i;
    end else if (step_i) begin
      if (!trial_s[WIDTH]) begin
        rem_q <= trial_s[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted_s[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle signed/unsigned multiply/divide unit with private HI/LO registers.
// Optional MULDIV_DIV0_TRAP_EN: divide by zero short-circuits and raises div_zero_o.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic             hilo_read_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
`ifdef MULDIV_DIV0_TRAP_EN
  output logic             div_zero_o,
`endif
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_mag_q, b_mag_q, hi_q, lo_q;
  logic               a_neg_q, b_neg_q, trap_q;
  logic [2*WIDTH-1:0] prod_q;

  logic               launch_s, trap_s, a_neg_s, b_neg_s, neg_s;
  logic               div_load_s, div_step_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, quot_s, rem_s, quot_fix_s, rem_fix_s;
  logic [2*WIDTH-1:0] prod_fix_s;

  // Launch decode and operand magnitudes (unsigned ops keep the raw value)
  always_comb begin
    launch_s = (state_q == ST_IDLE) && start_i && is_arith_op(op_i);
    a_neg_s  = is_signed_op(op_i) && a_i[WIDTH-1];
    b_neg_s  = is_signed_op(op_i) && b_i[WIDTH-1];
    a_mag_s  = a_neg_s ? ({WIDTH{1'b0}} - a_i) : a_i;
    b_mag_s  = b_neg_s ? ({WIDTH{1'b0}} - b_i) : b_i;
`ifdef MULDIV_DIV0_TRAP_EN
    trap_s   = launch_s && is_div_op(op_i) && (b_i == {WIDTH{1'b0}});
`else
    trap_s   = 1'b0;
`endif
  end

  // Next-state logic; a trapped divide hops through SIGN (no commit) so Done lands in cycle 2
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_load_s = 1'b0;
    div_step_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trap_s) begin
          state_d = ST_SIGN;
        end else if (launch_s && is_div_op(op_i)) begin
          state_d    = ST_DIV;
          cnt_d      = DIV_LAST;
          div_load_s = 1'b1;
        end else if (launch_s) begin
          state_d = ST_MUL;
          cnt_d   = MUL_LAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_SIGN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        div_step_s = 1'b1;
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_SIGN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SIGN: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and latched operand context
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 3'd0;
      a_mag_q <= {WIDTH{1'b0}};
      b_mag_q <= {WIDTH{1'b0}};
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (launch_s) begin
        op_q    <= op_i;
        a_mag_q <= a_mag_s;
        b_mag_q <= b_mag_s;
        a_neg_q <= a_neg_s;
        b_neg_q <= b_neg_s;
        trap_q  <= trap_s;
      end
    end
  end

  // Magnitude product, registered while in MUL
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= {2*WIDTH{1'b0}};
    end else if (state_q == ST_MUL) begin
      prod_q <= {{WIDTH{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q};
    end
  end

  muldiv_divider #(.WIDTH(WIDTH)) u_divider (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (div_load_s),
    .step_i     (div_step_s),
    .dividend_i (a_mag_s),
    .divisor_i  (b_mag_s),
    .quotient_o (quot_s),
    .remainder_o(rem_s)
  );

  // Sign fix-up; remainder follows the dividend's sign
  always_comb begin
    neg_s      = a_neg_q ^ b_neg_q;
    prod_fix_s = neg_s ? ({2*WIDTH{1'b0}} - prod_q) : prod_q;
    quot_fix_s = neg_s ? ({WIDTH{1'b0}} - quot_s) : quot_s;
    rem_fix_s  = a_neg_q ? ({WIDTH{1'b0}} - rem_s) : rem_s;
  end

  // HI/LO: mthi/mtlo writes in IDLE, results commit on the edge entering DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= {WIDTH{1'b0}};
      lo_q <= {WIDTH{1'b0}};
    end else if ((state_q == ST_IDLE) && start_i && (op_i == MD_MTHI)) begin
      hi_q <= a_i;
    end else if ((state_q == ST_IDLE) && start_i && (op_i == MD_MTLO)) begin
      lo_q <= a_i;
    end else if ((state_q == ST_SIGN) && !trap_q) begin
      if (is_div_op(op_q)) begin
        hi_q <= rem_fix_s;
        lo_q <= quot_fix_s;
      end else begin
        hi_q <= prod_fix_s[2*WIDTH-1:WIDTH];
        lo_q <= prod_fix_s[WIDTH-1:0];
      end
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign stall_o = busy_o & (hilo_read_i | start_i);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
`ifdef MULDIV_DIV0_TRAP_EN
  assign div_zero_o = done_o & trap_q;
`endif

endmodule
